mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the MIPS datapath (ifu, gprs, alu, ext, dm). It replaces the single-cycle combinational `co` decoder with a five-state FSM that breaks each instruction into fetch, decode, execute, memory and write-back cycles. It issues per-cycle write enables and mux selects to the datapath, supports a memory-wait hold, and counts retired instructions.

---
 rtl/mc_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller for the MIPS datapath.
// Splits each instruction into fetch/decode/execute/memory/write-back cycles.
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             Hold,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       NpcSel,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             RegDst,
    output logic             AluSrc,
    output logic             MemToReg,
    output logic             ExtOp,
    output logic [1:0]       AluOp,
    output logic [2:0]       State,
    output logic             Done,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExe    = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ClsNone = 4'd0,
        ClsAddu = 4'd1,
        ClsSubu = 4'd2,
        ClsOri  = 4'd3,
        ClsLui  = 4'd4,
        ClsLw   = 4'd5,
        ClsSw   = 4'd6,
        ClsBeq  = 4'd7,
        ClsJ    = 4'd8
    } cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, cls_dec;
    logic [CNT_W-1:0] retired_q;

    logic       ir_w, pc_w, reg_w, mem_w, done_raw, ill_raw;
    logic       exe_src, exe_ext;
    logic [1:0] exe_op;
    logic       en_ok;

    always_comb begin
        cls_dec = ClsNone;
        case (Op)
            6'b000000: begin
                case (Funct)
                    6'b100001: cls_dec = ClsAddu;
                    6'b100011: cls_dec = ClsSubu;
                    default:   cls_dec = ClsNone;
                endcase
            end
            6'b001101: cls_dec = ClsOri;
            6'b001111: cls_dec = ClsLui;
            6'b100011: cls_dec = ClsLw;
            6'b101011: cls_dec = ClsSw;
            6'b000100: cls_dec = ClsBeq;
            6'b000010: cls_dec = ClsJ;
            default:   cls_dec = ClsNone;
        endcase
    end

    // Datapath selects implied by the latched class; reused in EXE, MEM (lw) and WB.
    always_comb begin
        exe_src = 1'b0;
        exe_ext = 1'b0;
        exe_op  = 2'b00;
        case (cls_q)
            ClsSubu: exe_op = 2'b01;
            ClsOri: begin
                exe_src = 1'b1;
                exe_op  = 2'b10;
            end
            ClsLui: begin
                exe_src = 1'b1;
                exe_op  = 2'b11;
            end
            ClsLw, ClsSw: begin
                exe_src = 1'b1;
                exe_ext = 1'b1;
            end
            ClsBeq:  exe_op = 2'b01;
            default: exe_op = 2'b00;
        endcase
    end

    always_comb begin
        state_d  = StFetch;
        ir_w     = 1'b0;
        pc_w     = 1'b0;
        reg_w    = 1'b0;
        mem_w    = 1'b0;
        done_raw = 1'b0;
        ill_raw  = 1'b0;
        NpcSel   = 2'b00;
        RegDst   = 1'b0;
        AluSrc   = 1'b0;
        MemToReg = 1'b0;
        ExtOp    = 1'b0;
        AluOp    = 2'b00;
        case (state_q)
            StFetch: begin
                ir_w    = 1'b1;
                pc_w    = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                if (cls_dec == ClsJ) begin
                    pc_w     = 1'b1;
                    NpcSel   = 2'b10;
                    done_raw = 1'b1;
                end else if (cls_dec == ClsNone) begin
                    ill_raw = 1'b1;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                AluSrc = exe_src;
                ExtOp  = exe_ext;
                AluOp  = exe_op;
                case (cls_q)
                    ClsAddu, ClsSubu, ClsOri, ClsLui: state_d = StWb;
                    ClsLw, ClsSw:                     state_d = StMem;
                    ClsBeq: begin
                        NpcSel   = 2'b01;
                        pc_w     = Zero;
                        done_raw = 1'b1;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                if (cls_q == ClsLw) begin
                    AluSrc  = exe_src;
                    ExtOp   = exe_ext;
                    AluOp   = exe_op;
                    state_d = StWb;
                end else if (cls_q == ClsSw) begin
                    mem_w    = 1'b1;
                    done_raw = 1'b1;
                end
            end
            StWb: begin
                reg_w    = 1'b1;
                AluSrc   = exe_src;
                ExtOp    = exe_ext;
                AluOp    = exe_op;
                RegDst   = (cls_q == ClsAddu) || (cls_q == ClsSubu);
                MemToReg = (cls_q == ClsLw);
                done_raw = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StFetch;
            cls_q     <= ClsNone;
            retired_q <= '0;
        end else if (!Hold) begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                cls_q <= cls_dec;
            end
            if (done_raw) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Side-effecting strobes are suppressed during reset and hold; selects are not.
    assign en_ok    = !Reset && !Hold;
    assign IRWrite  = ir_w && en_ok;
    assign PCWrite  = pc_w && en_ok;
    assign RegWrite = reg_w && en_ok;
    assign MemWrite = mem_w && en_ok;
    assign Done     = done_raw && en_ok;
    assign Illegal  = ill_raw && en_ok;
    assign State    = state_q;
    assign Retired  = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; per-cycle state and packed control vector.
module tb_mc_ctrl;

    localparam int unsigned CW = 4;

    logic          Clk, Reset, Zero, Hold;
    logic [5:0]    Op, Funct;
    logic          IRWrite, PCWrite, RegWrite, MemWrite, RegDst, AluSrc, MemToReg, ExtOp;
    logic          Done, Illegal;
    logic [1:0]    NpcSel, AluOp;
    logic [2:0]    State;
    logic [CW-1:0] Retired;
    logic [13:0]   vec;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_ret;

    // {IRWrite, PCWrite, NpcSel, RegWrite, MemWrite, RegDst, AluSrc, MemToReg, ExtOp, AluOp,
    //  Done, Illegal}
    localparam logic [13:0] V_F      = 14'b11000000000000;
    localparam logic [13:0] V_0      = 14'b00000000000000;
    localparam logic [13:0] V_ADDU_W = 14'b00001010000010;
    localparam logic [13:0] V_LW_E   = 14'b00000001010000;
    localparam logic [13:0] V_LW_W   = 14'b00001001110010;
    localparam logic [13:0] V_SW_M   = 14'b00000100000010;
    localparam logic [13:0] V_BEQ_T  = 14'b01010000000110;
    localparam logic [13:0] V_BEQ_N  = 14'b00010000000110;
    localparam logic [13:0] V_ORI_E  = 14'b00000001001000;
    localparam logic [13:0] V_ORI_W  = 14'b00001001001010;
    localparam logic [13:0] V_LUI_E  = 14'b00000001001100;
    localparam logic [13:0] V_LUI_W  = 14'b00001001001110;
    localparam logic [13:0] V_ILL    = 14'b00000000000001;
    localparam logic [13:0] V_J      = 14'b01100000000010;

    mc_ctrl #(.CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero), .Hold(Hold),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .NpcSel(NpcSel), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .RegDst(RegDst), .AluSrc(AluSrc), .MemToReg(MemToReg),
        .ExtOp(ExtOp), .AluOp(AluOp), .State(State), .Done(Done), .Illegal(Illegal),
        .Retired(Retired)
    );

    assign vec = {IRWrite, PCWrite, NpcSel, RegWrite, MemWrite, RegDst, AluSrc, MemToReg,
                  ExtOp, AluOp, Done, Illegal};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Check state and control vector for the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [13:0] v);
        #1;
        check({tag, "_state"}, 32'(State), 32'(st));
        check({tag, "_ctrl"}, 32'(vec), 32'(v));
        @(posedge Clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] funct);
        Op    = op;
        Funct = funct;
    endtask

    initial begin
        Reset = 1'b0;
        Hold  = 1'b0;
        Zero  = 1'b0;
        Op    = 6'd0;
        Funct = 6'd0;
        exp_ret = '0;
        #1 Reset = 1'b1;
        #1;
        check("rst_state", 32'(State), 32'd0);
        check("rst_ctrl", 32'(vec), 32'(V_0));
        check("rst_ret", 32'(Retired), 32'd0);
        @(posedge Clk);
        #1 Reset = 1'b0;

        // addu
        set_instr(6'h00, 6'h21);
        cyc("addu_f", 3'd0, V_F);
        cyc("addu_d", 3'd1, V_0);
        cyc("addu_e", 3'd2, V_0);
        cyc("addu_w", 3'd4, V_ADDU_W);
        exp_ret = exp_ret + 1'b1;
        check("addu_ret", 32'(Retired), 32'(exp_ret));

        // lw
        set_instr(6'h23, 6'h00);
        cyc("lw_f", 3'd0, V_F);
        cyc("lw_d", 3'd1, V_0);
        cyc("lw_e", 3'd2, V_LW_E);
        cyc("lw_m", 3'd3, V_LW_E);
        cyc("lw_w", 3'd4, V_LW_W);
        exp_ret = exp_ret + 1'b1;
        check("lw_ret", 32'(Retired), 32'(exp_ret));

        // sw with a 3-cycle hold in MEM
        set_instr(6'h2b, 6'h00);
        cyc("sw_f", 3'd0, V_F);
        cyc("sw_d", 3'd1, V_0);
        cyc("sw_e", 3'd2, V_LW_E);
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) cyc("sw_hold", 3'd3, V_0);
        check("sw_hold_ret", 32'(Retired), 32'(exp_ret));
        Hold = 1'b0;
        cyc("sw_m", 3'd3, V_SW_M);
        exp_ret = exp_ret + 1'b1;
        #1;
        check("sw_next", 32'(State), 32'd0);
        check("sw_ret", 32'(Retired), 32'(exp_ret));

        // beq taken, then not taken
        set_instr(6'h04, 6'h00);
        Zero = 1'b1;
        cyc("beqt_f", 3'd0, V_F);
        cyc("beqt_d", 3'd1, V_0);
        cyc("beqt_e", 3'd2, V_BEQ_T);
        exp_ret = exp_ret + 1'b1;
        Zero = 1'b0;
        cyc("beqn_f", 3'd0, V_F);
        cyc("beqn_d", 3'd1, V_0);
        cyc("beqn_e", 3'd2, V_BEQ_N);
        exp_ret = exp_ret + 1'b1;
        check("beq_ret", 32'(Retired), 32'(exp_ret));

        // ori, lui
        set_instr(6'h0d, 6'h00);
        cyc("ori_f", 3'd0, V_F);
        cyc("ori_d", 3'd1, V_0);
        cyc("ori_e", 3'd2, V_ORI_E);
        cyc("ori_w", 3'd4, V_ORI_W);
        exp_ret = exp_ret + 1'b1;
        set_instr(6'h0f, 6'h00);
        cyc("lui_f", 3'd0, V_F);
        cyc("lui_d", 3'd1, V_0);
        cyc("lui_e", 3'd2, V_LUI_E);
        cyc("lui_w", 3'd4, V_LUI_W);
        exp_ret = exp_ret + 1'b1;
        check("lui_ret", 32'(Retired), 32'(exp_ret));

        // illegal opcode, then R-type with unknown funct
        set_instr(6'h3f, 6'h00);
        cyc("ill1_f", 3'd0, V_F);
        cyc("ill1_d", 3'd1, V_ILL);
        set_instr(6'h00, 6'h00);
        cyc("ill2_f", 3'd0, V_F);
        cyc("ill2_d", 3'd1, V_ILL);
        #1;
        check("ill_next", 32'(State), 32'd0);
        check("ill_ret", 32'(Retired), 32'(exp_ret));

        // 16 jumps wrap the 4-bit counter back to its starting value
        set_instr(6'h02, 6'h00);
        for (int i = 0; i < 16; i++) begin
            cyc("j_f", 3'd0, V_F);
            cyc("j_d", 3'd1, V_J);
            exp_ret = exp_ret + 1'b1;
            check("j_ret", 32'(Retired), 32'(exp_ret));
        end

        // reset asserted mid-WB aborts without committing the write
        set_instr(6'h00, 6'h21);
        cyc("rw_f", 3'd0, V_F);
        cyc("rw_d", 3'd1, V_0);
        cyc("rw_e", 3'd2, V_0);
        #1;
        check("rw_pre_regw", 32'(RegWrite), 32'd1);
        Reset = 1'b1;
        #1;
        check("rw_state", 32'(State), 32'd0);
        check("rw_regw", 32'(RegWrite), 32'd0);
        check("rw_done", 32'(Done), 32'd0);
        check("rw_ret", 32'(Retired), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
